wb_intercon_gen: RTL and testbench

- Parametrised successor to the single-master Wishbone interconnect between the multi-cycle CPU and its bus slaves (RAM, disk, VRAM, keyboard, counter).
- Generalised in slave count, address and data width, and decode field position.
- Adds registered request capture, per-transaction slave select latching, and a bus timeout with error response.
- Adds a faulting-address register and transaction and error counters for on-board display.

---
 rtl/wb_intercon_gen.sv | 185 ++++++++++++++++++
 tb/tb_wb_intercon_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon_gen.sv
// Single-master Wishbone interconnect: address-decoded slave select, registered
// request capture, bus timeout with error response, fault address and counters.
module wb_intercon_gen #(
    parameter int unsigned NUM_SLAVES = 5,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     RSTN,
    input  logic                     master_STB,
    input  logic                     master_WE,
    input  logic [AW-1:0]            master_ADDR,
    input  logic [DW-1:0]            master_DAT_I,
    output logic [DW-1:0]            master_DAT_O,
    output logic                     master_ACK,
    output logic                     master_ERR,
    output logic [NUM_SLAVES-1:0]    slave_STB,
    output logic                     slave_WE,
    output logic [AW-1:0]            slave_ADDR,
    output logic [DW-1:0]            slave_DAT_O,
    input  logic [NUM_SLAVES*DW-1:0] slave_DAT_I,
    input  logic [NUM_SLAVES-1:0]    slave_ACK,
    output logic [AW-1:0]            err_addr,
    output logic [15:0]              txn_count,
    output logic [7:0]               err_count
);

    localparam int unsigned SW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TERM   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned TXN_W  = 16;
    localparam int unsigned ERRC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [NUM_SLAVES-1:0] stb_d;
    logic                  we_d;
    logic [AW-1:0]         addr_d;
    logic [DW-1:0]         wdat_d;
    logic [DW-1:0]         rdat_d;
    logic                  ack_d, err_d;
    logic [AW-1:0]         eaddr_d;
    logic [TXN_W-1:0]      txn_d;
    logic [ERRC_W-1:0]     errc_d;

    logic [SEL_W-1:0]      idx_c;
    logic                  miss_c;
    logic                  ack_hit_c;
    logic [DW-1:0]         rdata_c;
    logic [ERRC_W-1:0]     errc_inc_c;

    // Decode field, out-of-range detection and saturating error increment
    assign idx_c      = master_ADDR[AW-1 -: SEL_W];
    assign miss_c     = 32'(idx_c) >= NUM_SLAVES;
    assign ack_hit_c  = |(slave_ACK & slave_STB);
    assign errc_inc_c = (err_count == '1) ? err_count : err_count + ERRC_W'(1);

    // Read-data mux for the latched slave
    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SW'(i)) begin
                rdata_c = slave_DAT_I[i*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        stb_d   = slave_STB;
        we_d    = slave_WE;
        addr_d  = slave_ADDR;
        wdat_d  = slave_DAT_O;
        rdat_d  = master_DAT_O;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        eaddr_d = err_addr;
        txn_d   = txn_count;
        errc_d  = err_count;
        case (state_q)
            ST_IDLE: begin
                stb_d = '0;
                if (master_STB) begin
                    if (miss_c) begin
                        eaddr_d = master_ADDR;
                        errc_d  = errc_inc_c;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        sel_d   = SW'(idx_c);
                        addr_d  = master_ADDR;
                        we_d    = master_WE;
                        wdat_d  = master_DAT_I;
                        stb_d   = NUM_SLAVES'(1) << idx_c;
                        timer_d = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (!master_STB) begin
                    // master withdrew the request: silent abort
                    stb_d   = '0;
                    state_d = ST_IDLE;
                end else if (ack_hit_c) begin
                    rdat_d  = rdata_c;
                    txn_d   = txn_count + TXN_W'(1);
                    ack_d   = 1'b1;
                    stb_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if ((TIMEOUT != 0) && (timer_q == TW'(TERM))) begin
                        eaddr_d = slave_ADDR;
                        errc_d  = errc_inc_c;
                        err_d   = 1'b1;
                        stb_d   = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                stb_d   = '0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                stb_d = '0;
                if (!master_STB) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                stb_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            sel_q        <= '0;
            slave_STB    <= '0;
            slave_WE     <= 1'b0;
            slave_ADDR   <= '0;
            slave_DAT_O  <= '0;
            master_DAT_O <= '0;
            master_ACK   <= 1'b0;
            master_ERR   <= 1'b0;
            err_addr     <= '0;
            txn_count    <= '0;
            err_count    <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sel_q        <= sel_d;
            slave_STB    <= stb_d;
            slave_WE     <= we_d;
            slave_ADDR   <= addr_d;
            slave_DAT_O  <= wdat_d;
            master_DAT_O <= rdat_d;
            master_ACK   <= ack_d;
            master_ERR   <= err_d;
            err_addr     <= eaddr_d;
            txn_count    <= txn_d;
            err_count    <= errc_d;
        end
    end

endmodule

// File: tb/tb_wb_intercon_gen.sv
// Scoreboard bench for wb_intercon_gen: randomized transactions against a
// transaction-level model, responses checked by an independent monitor.
module tb_wb_intercon_gen;

    localparam int NS = 5;
    localparam int TO = 8;

    logic              clk;
    logic              RSTN;
    logic              master_STB;
    logic              master_WE;
    logic [31:0]       master_ADDR;
    logic [31:0]       master_DAT_I;
    logic [31:0]       master_DAT_O;
    logic              master_ACK;
    logic              master_ERR;
    logic [NS-1:0]     slave_STB;
    logic              slave_WE;
    logic [31:0]       slave_ADDR;
    logic [31:0]       slave_DAT_O;
    logic [NS*32-1:0]  slave_DAT_I;
    logic [NS-1:0]     slave_ACK;
    logic [31:0]       err_addr;
    logic [15:0]       txn_count;
    logic [7:0]        err_count;

    wb_intercon_gen #(
        .NUM_SLAVES(NS), .AW(32), .DW(32), .SEL_W(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .RSTN(RSTN),
        .master_STB(master_STB), .master_WE(master_WE), .master_ADDR(master_ADDR),
        .master_DAT_I(master_DAT_I), .master_DAT_O(master_DAT_O),
        .master_ACK(master_ACK), .master_ERR(master_ERR),
        .slave_STB(slave_STB), .slave_WE(slave_WE), .slave_ADDR(slave_ADDR),
        .slave_DAT_O(slave_DAT_O), .slave_DAT_I(slave_DAT_I), .slave_ACK(slave_ACK),
        .err_addr(err_addr), .txn_count(txn_count), .err_count(err_count)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        logic [15:0] txn;
        logic [7:0]  errc;
        logic [31:0] eaddr;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_dat   = '0;
    int          m_txn   = 0;
    int          m_err   = 0;
    logic [31:0] m_eaddr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse is matched to the oldest expected response
    always @(negedge clk) begin
        if (RSTN && (master_ACK || master_ERR)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", master_ACK, master_ERR);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_err",  64'(master_ERR),   64'(mon_e.is_err));
                check("resp_ack",  64'(master_ACK),   64'(!mon_e.is_err));
                check("dat_o",     64'(master_DAT_O), 64'(mon_e.dat));
                check("txn_count", 64'(txn_count),    64'(mon_e.txn));
                check("err_count", 64'(err_count),    64'(mon_e.errc));
                check("err_addr",  64'(err_addr),     64'(mon_e.eaddr));
            end
        end
    end

    // One complete master transaction; lat = STB cycle on which the slave ACKs (0 = never)
    task automatic do_txn(input logic [31:0] addr, input bit we, input logic [31:0] wdat,
                          input int lat, input logic [31:0] rdat, input int hold);
        int          idx;
        bit          miss;
        bit          acks;
        int          exp_stb;
        int          cyc;
        int          stb_cnt;
        bit          got;
        logic [NS-1:0] oh;
        resp_t       e;

        idx     = int'(addr[31:28]);
        miss    = idx >= NS;
        acks    = !miss && (lat != 0) && (lat <= TO);
        exp_stb = miss ? 0 : (acks ? lat : TO);
        oh      = miss ? '0 : (NS'(1) << idx);

        if (acks) begin
            m_dat = rdat;
            m_txn = (m_txn + 1) % 65536;
        end else begin
            m_eaddr = addr;
            if (m_err < 255) m_err++;
        end
        e.is_err = !acks;
        e.dat    = m_dat;
        e.txn    = 16'(m_txn);
        e.errc   = 8'(m_err);
        e.eaddr  = m_eaddr;
        exp_q.push_back(e);

        master_STB   = 1'b1;
        master_WE    = we;
        master_ADDR  = addr;
        master_DAT_I = wdat;
        for (int i = 0; i < NS; i++) slave_DAT_I[i*32 +: 32] = $urandom;
        if (!miss) slave_DAT_I[idx*32 +: 32] = rdat;

        cyc = 0; stb_cnt = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (master_ACK || master_ERR) begin
                got = 1;
                check("latency", 64'(cyc), 64'(exp_stb + 1));
                check("stb_off_at_resp", 64'(slave_STB), 64'(0));
                slave_ACK = '0;
            end else begin
                slave_ACK = NS'($urandom) & ~oh;
                if (slave_STB != '0) begin
                    stb_cnt++;
                    check("stb_onehot", 64'(slave_STB), 64'(oh));
                    if (stb_cnt == 1) begin
                        check("slave_addr", 64'(slave_ADDR),  64'(addr));
                        check("slave_we",   64'(slave_WE),    64'(we));
                        check("slave_dat",  64'(slave_DAT_O), 64'(wdat));
                    end
                    if (stb_cnt == lat) slave_ACK = slave_ACK | oh;
                end
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got no response expected one within 40 cycles");
        end
        check("stb_cycles", 64'(stb_cnt), 64'(exp_stb));

        // STB held after the response, with stray ACKs: nothing may happen
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_no_resp", 64'(master_ACK | master_ERR), 64'(0));
            check("hold_no_stb",  64'(slave_STB), 64'(0));
            slave_ACK = NS'($urandom) | oh;
        end
        master_STB = 1'b0;
        slave_ACK  = '0;
        repeat (2) begin
            @(negedge clk);
            check("idle_no_stb", 64'(slave_STB | {4'b0, master_ACK | master_ERR}), 64'(0));
        end
        if (!miss) check("addr_held", 64'(slave_ADDR), 64'(addr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        RSTN = 1'b0; master_STB = 1'b0; master_WE = 1'b0; master_ADDR = '0;
        master_DAT_I = '0; slave_DAT_I = '0; slave_ACK = '0;
        #22;
        check("rst_stb",  64'(slave_STB), 64'(0));
        check("rst_resp", 64'({master_ACK, master_ERR}), 64'(0));
        check("rst_cnt",  64'({txn_count, err_count}), 64'(0));
        check("rst_regs", 64'(master_DAT_O | err_addr | slave_ADDR), 64'(0));
        @(negedge clk); RSTN = 1'b1;
        @(negedge clk);

        // directed cases
        do_txn(32'h2000_0010, 1'b0, 32'h0,         3, 32'hDEADBEEF, 0);
        do_txn(32'h0000_0040, 1'b1, 32'h1234_5678, 1, 32'h0BAD_F00D, 3);
        do_txn(32'h9000_0000, 1'b0, 32'h0,         1, 32'h0,         1);
        do_txn(32'h1000_0100, 1'b0, 32'h0,         0, 32'h5555_AAAA, 3);
        do_txn(32'h3000_0008, 1'b0, 32'h0,        TO, 32'hC0FF_EE00, 0);

        // abort: STB dropped mid-BUSY gives no response and no counter change
        master_STB = 1'b1; master_WE = 1'b0; master_ADDR = 32'h1000_0000;
        repeat (3) @(negedge clk);
        master_STB = 1'b0;
        @(negedge clk);
        check("abort_stb",  64'(slave_STB), 64'(0));
        check("abort_cnt",  64'({txn_count, err_count}), 64'({16'(m_txn), 8'(m_err)}));
        @(negedge clk);

        // randomized traffic, including decode misses and timeouts
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = $urandom;
            a[31:28] = 4'($urandom_range(0, 7));
            do_txn(a, 1'($urandom), $urandom, $urandom_range(0, TO + 2), $urandom,
                   $urandom_range(0, 3));
        end

        // asynchronous reset in the middle of a BUSY phase
        master_STB = 1'b1; master_ADDR = 32'h2000_0000;
        repeat (3) @(negedge clk);
        #2 RSTN = 1'b0;
        #1;
        check("mrst_stb",  64'(slave_STB), 64'(0));
        check("mrst_ack",  64'(master_ACK), 64'(0));
        check("mrst_cnt",  64'({txn_count, err_count}), 64'(0));
        master_STB = 1'b0;
        m_txn = 0; m_err = 0; m_dat = '0; m_eaddr = '0;
        @(negedge clk); RSTN = 1'b1;
        @(negedge clk);
        do_txn(32'h4000_0020, 1'b0, 32'h0, 2, 32'hA5A5_5A5A, 1);

        // error counter saturation
        for (int n = 0; n < 260; n++) begin
            logic [31:0] a;
            a = $urandom;
            a[31:28] = 4'($urandom_range(5, 7));
            do_txn(a, 1'b0, $urandom, 1, $urandom, 0);
        end
        check("err_sat", 64'(err_count), 64'(8'hFF));
        check("txn_after_sat", 64'(txn_count), 64'(1));
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
